// File: rtl/reaction_game_ctrl.sv
// Multi-round keyboard reaction game: LFSR target draw, timed response, hit/miss/timeout scoring.
// Define REACT_TIME_CAPTURE_EN to build last/best reaction-time capture.
module reaction_game_ctrl #(
    parameter int unsigned CODE_W       = 5,
    parameter int unsigned RELEASE_CODE = 21,
    parameter int unsigned NUM_LETTERS  = 26,
    parameter int unsigned TIMER_W      = 27,
    parameter int unsigned TIMEOUT      = 100_000_000,
    parameter int unsigned ROUNDS       = 10,
    parameter int unsigned SCORE_W      = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CODE_W-1:0]  key_code,
    output logic [CODE_W-1:0]  goal_code,
    output logic [2:0]         state_o,
    output logic [TIMER_W-1:0] timer_cnt,
    output logic [SCORE_W-1:0] hits,
    output logic [SCORE_W-1:0] misses,
    output logic               timed_out,
    output logic               win_pulse,
    output logic               lose_pulse,
    output logic [TIMER_W-1:0] last_rt,
    output logic [TIMER_W-1:0] best_rt
);

    localparam int unsigned RND_W = $clog2(ROUNDS + 1);
    localparam logic [CODE_W-1:0]  REL_C    = CODE_W'(RELEASE_CODE);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [RND_W-1:0]   RND_MAX  = RND_W'(ROUNDS);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StGen  = 3'd1,
        StPlay = 3'd2,
        StWin  = 3'd3,
        StLose = 3'd4,
        StDone = 3'd5
    } state_e;

    state_e             r_state;
    logic [CODE_W-1:0]  r_key_prev;
    logic [15:0]        r_lfsr;
    logic [CODE_W-1:0]  r_goal;
    logic [TIMER_W-1:0] r_timer;
    logic [SCORE_W-1:0] r_hits;
    logic [SCORE_W-1:0] r_misses;
    logic [RND_W-1:0]   r_rounds;
    logic               r_timed_out;
    logic               r_win_pulse;
    logic               r_lose_pulse;

    logic               w_key_evt;
    logic               w_rel_evt;
    logic               w_press_evt;
    logic [15:0]        w_lfsr_next;
    logic [CODE_W-1:0]  w_cand;
    logic               w_cand_ok;
    logic [TIMER_W-1:0] w_rt_new;

    assign w_key_evt   = (key_code != r_key_prev);
    assign w_rel_evt   = w_key_evt && (key_code == REL_C);
    assign w_press_evt = w_key_evt && (key_code != REL_C);

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_cand      = r_lfsr[CODE_W-1:0];
    assign w_cand_ok   = (32'(w_cand) < NUM_LETTERS) && (w_cand != REL_C);
    assign w_rt_new    = r_timer + TIMER_W'(1);

`ifdef REACT_TIME_CAPTURE_EN
    logic [TIMER_W-1:0] r_last_rt;
    logic [TIMER_W-1:0] r_best_rt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_rt <= '0;
            r_best_rt <= '1;
        end else if (r_state == StPlay && w_press_evt && key_code == r_goal) begin
            r_last_rt <= w_rt_new;
            if (w_rt_new < r_best_rt) begin
                r_best_rt <= w_rt_new;
            end
        end
    end

    assign last_rt = r_last_rt;
    assign best_rt = r_best_rt;
`else
    assign last_rt = '0;
    assign best_rt = '1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_key_prev   <= REL_C;
            r_lfsr       <= LFSR_SEED;
            r_goal       <= '0;
            r_timer      <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_rounds     <= '0;
            r_timed_out  <= 1'b0;
            r_win_pulse  <= 1'b0;
            r_lose_pulse <= 1'b0;
        end else begin
            r_key_prev   <= key_code;
            r_lfsr       <= w_lfsr_next;
            r_win_pulse  <= 1'b0;
            r_lose_pulse <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_timer <= '0;
                    if (w_rel_evt) begin
                        r_state <= StGen;
                    end
                end
                StGen: begin
                    if (w_cand_ok) begin
                        r_goal  <= w_cand;
                        r_timer <= '0;
                        r_state <= StPlay;
                    end
                end
                StPlay: begin
                    // A press wins over a coincident timeout; the timer is frozen on exit
                    if (w_press_evt) begin
                        r_rounds <= r_rounds + RND_W'(1);
                        if (key_code == r_goal) begin
                            r_state     <= StWin;
                            r_win_pulse <= 1'b1;
                            if (r_hits != '1) begin
                                r_hits <= r_hits + SCORE_W'(1);
                            end
                        end else begin
                            r_state      <= StLose;
                            r_lose_pulse <= 1'b1;
                            if (r_misses != '1) begin
                                r_misses <= r_misses + SCORE_W'(1);
                            end
                        end
                    end else if (r_timer == TMO_LAST) begin
                        r_rounds     <= r_rounds + RND_W'(1);
                        r_state      <= StLose;
                        r_lose_pulse <= 1'b1;
                        r_timed_out  <= 1'b1;
                        if (r_misses != '1) begin
                            r_misses <= r_misses + SCORE_W'(1);
                        end
                    end else begin
                        r_timer <= w_rt_new;
                    end
                end
                StWin, StLose: begin
                    if (w_rel_evt) begin
                        r_timed_out <= 1'b0;
                        r_state     <= (r_rounds == RND_MAX) ? StDone : StGen;
                    end
                end
                StDone: begin
                    if (w_rel_evt) begin
                        r_hits   <= '0;
                        r_misses <= '0;
                        r_rounds <= '0;
                        r_state  <= StGen;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign goal_code  = r_goal;
    assign state_o    = r_state;
    assign timer_cnt  = r_timer;
    assign hits       = r_hits;
    assign misses     = r_misses;
    assign timed_out  = r_timed_out;
    assign win_pulse  = r_win_pulse;
    assign lose_pulse = r_lose_pulse;

endmodule
